// File: rtl/message_bit_feeder.sv
// Holds a byte-loaded message and feeds it FRAME_SIZE bits at a time, LSB first, wrapping at the end.
// Latency: sample-consumed edge -> next chunk on out_message one cycle later; out_message is registered.
module message_bit_feeder #(
    parameter int FRAME_SIZE = 1,
    parameter int MSG_BYTES  = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_load_start,
    input  logic                  in_load_valid,
    input  logic [7:0]            in_load_byte,
    input  logic                  in_load_done,
    input  logic                  in_sample_ready,
    output logic [FRAME_SIZE-1:0] out_message,
    output logic                  out_message_valid,
    output logic [ADDR_W:0]       out_msg_len,
    output logic                  out_full,
    output logic                  out_wrap
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(MSG_BYTES);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [2:0]        BIT_STEP = 3'(FRAME_SIZE);
    localparam logic [2:0]        LAST_BIT = 3'(8 - FRAME_SIZE);

    state_t            state, state_nxt;
    logic [7:0]        mem [MSG_BYTES];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] byte_ptr, byte_ptr_nxt;
    logic [2:0]        bit_ptr, bit_ptr_nxt;
    logic [ADDR_W:0]   len_nxt, last_byte;
    logic              wr_en, byte_end, msg_end, advance;
    logic [7:0]        first_byte, next_byte;

    assign wr_en     = (state == LOAD) && in_load_valid && !in_load_start && (out_msg_len < MAX_LEN);
    assign len_nxt   = wr_en ? out_msg_len + LEN_ONE : out_msg_len;
    assign last_byte = out_msg_len - LEN_ONE;
    assign advance   = (state == RUN) && in_sample_ready;
    assign byte_end  = (bit_ptr == LAST_BIT);
    assign msg_end   = byte_end && ({1'b0, byte_ptr} == last_byte);

    // A byte written on the same edge as load_done is not in mem yet; forward it.
    assign first_byte = (wr_en && (wr_ptr == '0)) ? in_load_byte : mem[0];
    assign next_byte  = mem[byte_ptr_nxt];

    always_comb begin
        bit_ptr_nxt  = byte_end ? 3'd0 : bit_ptr + BIT_STEP;
        byte_ptr_nxt = byte_ptr;
        if (msg_end) begin
            byte_ptr_nxt = '0;
        end else if (byte_end) begin
            byte_ptr_nxt = byte_ptr + PTR_ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        if (in_load_start) begin
            state_nxt = LOAD;
        end else if (state == LOAD && in_load_done) begin
            state_nxt = (len_nxt != '0) ? RUN : IDLE;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge in_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_load_byte;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_ptr            <= '0;
            byte_ptr          <= '0;
            bit_ptr           <= '0;
            out_message       <= '0;
            out_message_valid <= 1'b0;
            out_msg_len       <= '0;
            out_full          <= 1'b0;
            out_wrap          <= 1'b0;
        end else begin
            out_wrap          <= 1'b0;
            out_message_valid <= (state_nxt == RUN);
            if (in_load_start) begin
                wr_ptr      <= '0;
                byte_ptr    <= '0;
                bit_ptr     <= '0;
                out_message <= '0;
                out_msg_len <= '0;
                out_full    <= 1'b0;
            end else if (state == LOAD) begin
                if (wr_en) begin
                    wr_ptr      <= wr_ptr + PTR_ONE;
                    out_msg_len <= len_nxt;
                    out_full    <= (len_nxt == MAX_LEN);
                end
                if (in_load_done && len_nxt != '0) begin
                    byte_ptr    <= '0;
                    bit_ptr     <= '0;
                    out_message <= first_byte[FRAME_SIZE-1:0];
                end
            end else if (advance) begin
                bit_ptr     <= bit_ptr_nxt;
                byte_ptr    <= byte_ptr_nxt;
                out_message <= next_byte[bit_ptr_nxt +: FRAME_SIZE];
                out_wrap    <= msg_end;
            end
        end
    end

endmodule

// File: tb/tb_message_bit_feeder.sv
// Bench for message_bit_feeder: FRAME_SIZE=1 and FRAME_SIZE=4 instances share one stimulus stream.
module tb_message_bit_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0, load_valid = 1'b0, load_done = 1'b0, sample_ready = 1'b0;
    logic [7:0] load_byte = 8'h00;

    logic       msg1, vld1, full1, wrap1;
    logic [4:0] len1;
    logic [3:0] msg4;
    logic       vld4, full4, wrap4;
    logic [4:0] len4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    message_bit_feeder #(.FRAME_SIZE(1), .MSG_BYTES(16), .ADDR_W(4)) dut1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_load_start(load_start), .in_load_valid(load_valid),
        .in_load_byte(load_byte), .in_load_done(load_done), .in_sample_ready(sample_ready),
        .out_message(msg1), .out_message_valid(vld1), .out_msg_len(len1),
        .out_full(full1), .out_wrap(wrap1)
    );

    message_bit_feeder #(.FRAME_SIZE(4), .MSG_BYTES(16), .ADDR_W(4)) dut4 (
        .in_clk(clk), .in_rst_n(rst_n), .in_load_start(load_start), .in_load_valid(load_valid),
        .in_load_byte(load_byte), .in_load_done(load_done), .in_sample_ready(sample_ready),
        .out_message(msg4), .out_message_valid(vld4), .out_msg_len(len4),
        .out_full(full4), .out_wrap(wrap4)
    );

    // Reference model: message as a byte list, progress as a chunk count.
    int        m_mode;     // 0 idle, 1 load, 2 run
    bit [7:0]  m_msg[$];
    int        m_k1, m_k4;
    bit        m_w1, m_w4;

    function automatic int chunk(int fs, int k);
        int bitpos = k * fs;
        return (int'(m_msg[bitpos / 8]) >> (bitpos % 8)) & ((1 << fs) - 1);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_msg.delete(); m_k1 = 0; m_k4 = 0; m_w1 = 0; m_w4 = 0;
    endtask

    task automatic model_edge(bit s, bit v, bit [7:0] b, bit d, bit r);
        m_w1 = 0; m_w4 = 0;
        if (s) begin
            m_mode = 1; m_msg.delete(); m_k1 = 0; m_k4 = 0;
        end else if (m_mode == 1) begin
            if (v && m_msg.size() < 16) m_msg.push_back(b);
            if (d) begin
                m_mode = (m_msg.size() > 0) ? 2 : 0;
                m_k1 = 0; m_k4 = 0;
            end
        end else if (m_mode == 2 && r) begin
            m_k1++; m_k4++;
            if (m_k1 == m_msg.size() * 8)     begin m_k1 = 0; m_w1 = 1; end
            if (m_k4 == m_msg.size() * 8 / 4) begin m_k4 = 0; m_w4 = 1; end
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("fs1_message", int'(msg1), (m_mode == 2) ? chunk(1, m_k1) : 0);
        check("fs4_message", int'(msg4), (m_mode == 2) ? chunk(4, m_k4) : 0);
        check("valid",       int'(vld1), int'(m_mode == 2));
        check("valid4",      int'(vld4), int'(m_mode == 2));
        check("msg_len",     int'(len1), m_msg.size());
        check("full",        int'(full1), int'(m_msg.size() == 16));
        check("fs1_wrap",    int'(wrap1), int'(m_w1));
        check("fs4_wrap",    int'(wrap4), int'(m_w4));
    endtask

    // One clock: drive inputs, take the edge, update model, settle 1 time unit.
    task automatic cyc(bit s, bit v, bit [7:0] b, bit d, bit r);
        load_start = s; load_valid = v; load_byte = b; load_done = d; sample_ready = r;
        @(posedge clk);
        model_edge(s, v, b, d, r);
        #1;
    endtask

    typedef struct {
        bit s, v; bit [7:0] b; bit d, r;
        int m1, w1, m4, w4, vld, len;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(bit s, bit v, bit [7:0] b, bit d, bit r,
                           int m1, int w1, int m4, int w4, int vld, int len);
        vec_t t;
        t.s = s; t.v = v; t.b = b; t.d = d; t.r = r;
        t.m1 = m1; t.w1 = w1; t.m4 = m4; t.w4 = w4; t.vld = vld; t.len = len;
        tbl.push_back(t);
    endtask

    initial begin
        int exp4[4];
        model_reset();

        //        s v byte  d r   m1 w1 m4   w4 vld len
        add_vec(1,0,8'h00,0,0,   0, 0, 0,   0, 0, 0);
        add_vec(0,1,8'hA5,0,0,   0, 0, 0,   0, 0, 1);
        add_vec(0,1,8'h3C,0,0,   0, 0, 0,   0, 0, 2);
        add_vec(0,0,8'h00,1,0,   1, 0, 5,   0, 1, 2);
        add_vec(0,0,8'h00,0,1,   0, 0, 'hA, 0, 1, 2);
        add_vec(0,0,8'h00,0,1,   1, 0, 'hC, 0, 1, 2);
        add_vec(0,0,8'h00,0,1,   0, 0, 3,   0, 1, 2);
        add_vec(0,0,8'h00,0,1,   0, 0, 5,   1, 1, 2);
        add_vec(0,0,8'h00,0,0,   0, 0, 5,   0, 1, 2);
        add_vec(0,0,8'h00,0,1,   1, 0, 'hA, 0, 1, 2);
        add_vec(0,0,8'h00,0,1,   0, 0, 'hC, 0, 1, 2);
        add_vec(0,0,8'h00,0,1,   1, 0, 3,   0, 1, 2);
        add_vec(0,0,8'h00,0,1,   0, 0, 5,   1, 1, 2);
        add_vec(0,0,8'h00,0,1,   0, 0, 'hA, 0, 1, 2);
        add_vec(0,0,8'h00,0,1,   1, 0, 'hC, 0, 1, 2);
        add_vec(0,0,8'h00,0,1,   1, 0, 3,   0, 1, 2);
        add_vec(0,0,8'h00,0,1,   1, 0, 5,   1, 1, 2);
        add_vec(0,0,8'h00,0,1,   1, 0, 'hA, 0, 1, 2);
        add_vec(0,0,8'h00,0,1,   0, 0, 'hC, 0, 1, 2);
        add_vec(0,0,8'h00,0,1,   0, 0, 3,   0, 1, 2);
        add_vec(0,0,8'h00,0,1,   1, 1, 5,   1, 1, 2);

        // Reset state, sampled while reset is held.
        #2;
        check("rst_message", int'(msg1), 0);
        check("rst_valid",   int'(vld1), 0);
        check("rst_len",     int'(len1), 0);
        check("rst_full",    int'(full1), 0);
        check("rst_wrap",    int'(wrap1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].d, tbl[i].r);
            check($sformatf("tbl%0d_m1", i),  int'(msg1),  tbl[i].m1);
            check($sformatf("tbl%0d_w1", i),  int'(wrap1), tbl[i].w1);
            check($sformatf("tbl%0d_m4", i),  int'(msg4),  tbl[i].m4);
            check($sformatf("tbl%0d_w4", i),  int'(wrap4), tbl[i].w4);
            check($sformatf("tbl%0d_vld", i), int'(vld1),  tbl[i].vld);
            check($sformatf("tbl%0d_len", i), int'(len1),  tbl[i].len);
        end

        // FRAME_SIZE=4, 0x5A 0xC3, back-to-back pulses.
        cyc(1, 0, 8'h00, 0, 0);
        cyc(0, 1, 8'h5A, 0, 0);
        cyc(0, 1, 8'hC3, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        check("fs4_chunk0", int'(msg4), 'hA);
        exp4 = '{5, 3, 'hC, 'hA};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'h00, 0, 1);
            check($sformatf("fs4_b2b%0d", i), int'(msg4), exp4[i]);
            check($sformatf("fs4_b2b_wrap%0d", i), int'(wrap4), int'(i == 3));
        end

        // Overflow: 17 bytes, the 17th dropped; full wrap after 128 one-bit chunks.
        cyc(1, 0, 8'h00, 0, 0);
        for (int i = 0; i <= 16; i++) begin
            cyc(0, 1, 8'(i), 0, 0);
            check_model();
        end
        cyc(0, 0, 8'h00, 1, 0);
        check("ovf_full", int'(full1), 1);
        check("ovf_len",  int'(len1), 16);
        for (int i = 0; i < 128; i++) begin
            cyc(0, 0, 8'h00, 0, 1);
            check_model();
            check("ovf_wrap128", int'(wrap1), int'(i == 127));
        end

        // Start with a simultaneous byte, then done: nothing stored.
        cyc(1, 1, 8'h77, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        check("empty_len",   int'(len1), 0);
        check("empty_valid", int'(vld1), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 8'h00, 0, 1);
            check("empty_msg1", int'(msg1), 0);
            check("empty_msg4", int'(msg4), 0);
        end

        // Reload in the middle of a run restarts from bit 0 of the new message.
        cyc(1, 0, 8'h00, 0, 0);
        cyc(0, 1, 8'hA5, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'h00, 0, 0);
        check("reload_abort_valid", int'(vld1), 0);
        check("reload_abort_msg",   int'(msg1), 0);
        cyc(0, 1, 8'hFF, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        check("reload_first", int'(msg1), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 8'h00, 0, 1);
            check("reload_next", int'(msg1), 1);
            check("reload_next4", int'(msg4), 'hF);
        end

        // Asynchronous reset between edges.
        cyc(0, 0, 8'h00, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_message", int'(msg1), 0);
        check("arst_valid",   int'(vld1), 0);
        check("arst_len",     int'(len1), 0);
        check("arst_wrap",    int'(wrap1) | int'(wrap4), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/message_bit_feeder.md
Name: message_bit_feeder

Overview:
- Upstream neighbour of bit_changer_seq; supplies its in_message input.
- Stores a hidden message loaded byte-by-byte, typically from a uart_rx o_Rx_DV/o_Rx_Byte pair.
- Each time a sample is handed to the bit changer (uart2sample out_ready), it steps to the next FRAME_SIZE message bits, LSB first, and wraps to the start after the last byte.

Parameters:
FRAME_SIZE, 1, message bits per sample; legal values 1, 2, 4, 8 (must divide 8)
MSG_BYTES, 16, message buffer depth in bytes (power of 2, >=2)
ADDR_W, 4, log2(MSG_BYTES)

Ports:
in_clk  input  1  system clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_load_start  input  1  one-cycle pulse: discard old message, begin loading
in_load_valid  input  1  one-cycle byte strobe while loading
in_load_byte  input  8  message byte, sampled when in_load_valid=1
in_load_done  input  1  one-cycle pulse: end loading, start feeding
in_sample_ready  input  1  sample-consumed pulse (same signal as bit_changer_seq in_enable)
out_message  output  FRAME_SIZE  current message chunk to bit_changer_seq in_message
out_message_valid  output  1  high in RUN only
out_msg_len  output  ADDR_W+1  number of bytes stored
out_full  output  1  buffer holds MSG_BYTES bytes
out_wrap  output  1  one-cycle pulse when the final chunk is consumed

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: in_clk, in_rst_n.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - wr_ptr=0, byte_ptr=0, bit_ptr=0.
  - Buffer contents don't-care.
- States:
  - IDLE: no message.
  - LOAD: accepting bytes.
  - RUN: feeding chunks.
- in_load_start, from any state, highest priority:
  - Next state LOAD; wr_ptr, out_msg_len, byte_ptr and bit_ptr clear to 0.
  - out_message=0, out_message_valid=0, out_full=0.
  - A simultaneous in_load_valid byte is dropped.
- LOAD:
  - in_load_valid with out_msg_len<MSG_BYTES writes mem[wr_ptr]. wr_ptr and out_msg_len each increment by 1.
  - out_full rises the cycle after the MSG_BYTES-th write. Further bytes are silently ignored.
  - in_load_done: next state RUN if the length including any same-cycle write is >0, otherwise IDLE.
  - In RUN, out_message is registered with chunk 0 = mem[0][FRAME_SIZE-1:0] and out_message_valid=1 on the same edge.
- RUN:
  - out_message = mem[byte_ptr][bit_ptr+:FRAME_SIZE], held stable between pulses.
  - On an edge with in_sample_ready=1, bit_ptr += FRAME_SIZE. The new chunk is visible the next cycle.
  - Net effect: bit_changer_seq consumes the old chunk on the same edge as its in_enable.
  - When bit_ptr wraps past 7, byte_ptr increments.
  - When the last chunk of byte out_msg_len-1 is consumed, byte_ptr=0 and bit_ptr=0, and out_wrap=1 for exactly one cycle.
  - Back-to-back in_sample_ready pulses advance one chunk per cycle.
- Ignored inputs:
  - in_load_valid and in_load_done outside LOAD.
  - in_sample_ready outside RUN; out_message stays 0 there.
- Loading order is LSB first within a byte, byte 0 first.
- Re-load mid-RUN: in_load_start aborts feeding immediately.
- Reset mid-operation: immediate return to reset values, independent of in_clk.
- Latency: pulse edge -> next chunk on out_message, 1 cycle.
- No combinational path from in_sample_ready to out_message.

Test Plan:
- Reset, then in_load_start, bytes 0xA5, 0x3C, in_load_done (FRAME_SIZE=1):
  - out_message_valid=1, out_msg_len=2.
  - Over 16 in_sample_ready pulses, out_message = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - out_wrap pulses once after the 16th pulse; out_message then returns to 1.
- FRAME_SIZE=4, load 0x5A, 0xC3:
  - Chunks 0xA, 0x5, 0x3, 0xC.
  - out_wrap after the 4th pulse.
  - Back-to-back pulses on 4 consecutive cycles give the same sequence.
- Load 17 bytes 0x00..0x10 (MSG_BYTES=16):
  - out_full=1, out_msg_len=16.
  - After 128 pulses (FRAME_SIZE=1) the wrap occurs and byte 0x10 never appears.
- in_load_start in the same cycle as in_load_valid, then in_load_done:
  - out_msg_len=0, state IDLE, out_message_valid=0.
  - in_sample_ready pulses leave out_message=0.
- Mid-RUN after 5 pulses:
  - Reload with 0xFF: outputs restart at 1, 1, ... from bit 0.
  - Alternatively, assert in_rst_n=0 between clock edges: all outputs go 0 immediately.
- Full chain: uart_rx -> uart2sample -> bit_changer_seq, with message byte 0x01 loaded and samples 0x3FFF and 0x01F0 received:
  - out_frame LSBs are 1 then 0.
